// File: rtl/icw_sequencer_if.sv
// CPU-side write bus of the ICW/OCW sequencer: chip select, write strobe,
// address bit and the internal data bus byte.
interface icw_sequencer_if;
    logic       CS_N;
    logic       WR_N;
    logic       A0;
    logic [7:0] InternalData_in;

    modport master (
        output CS_N,
        output WR_N,
        output A0,
        output InternalData_in
    );

    modport slave (
        input CS_N,
        input WR_N,
        input A0,
        input InternalData_in
    );
endinterface

// File: rtl/icw_sequencer.sv
// 8259-style initialization/operation command word sequencer, committing each
// CPU write on the rising WR_N edge. Optional macro: OCW3_DECODE_EN (OCW3 decode).
module icw_sequencer (
    input  logic                  CLK,
    input  logic                  RST_N,
    icw_sequencer_if.slave        bus,
    output logic                  init_done,
    output logic [4:0]            vector_base,
    output logic                  ltim,
    output logic                  sngl,
    output logic                  ic4,
    output logic [7:0]            icw3,
    output logic                  aeoi,
    output logic                  upm,
    output logic [7:0]            imr,
    output logic [7:0]            ocw2,
    output logic                  ocw2_valid,
    output logic                  ocw3_rr,
    output logic                  ocw3_ris,
    output logic                  ocw3_smm
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     state_r;
    logic       wr_n_r;
    logic       cs_n_r;
    logic       a0_r;
    logic [7:0] data_r;
    logic       commit_s;
    logic       icw1_s;

    // Capture the bus on every low WR_N sample; the last low sample wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_n_r <= 1'b1;
            cs_n_r <= 1'b1;
            a0_r   <= 1'b0;
            data_r <= 8'h00;
        end else begin
            wr_n_r <= bus.WR_N;
            if (!bus.WR_N) begin
                cs_n_r <= bus.CS_N;
                a0_r   <= bus.A0;
                data_r <= bus.InternalData_in;
            end
        end
    end

    // Commit on the first high WR_N sample following a low one, if selected.
    always_comb begin
        commit_s = 1'b0;
        icw1_s   = 1'b0;
        if (!wr_n_r && bus.WR_N && !cs_n_r) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        if (!a0_r && data_r[4]) begin
            icw1_s = 1'b1;
        end else begin
            icw1_s = 1'b0;
        end
    end

    // Initialization sequence FSM and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            init_done   <= 1'b0;
            vector_base <= 5'h00;
            ltim        <= 1'b0;
            sngl        <= 1'b0;
            ic4         <= 1'b0;
            icw3        <= 8'h00;
            aeoi        <= 1'b0;
            upm         <= 1'b0;
            imr         <= 8'hFF;
            ocw2        <= 8'h00;
            ocw2_valid  <= 1'b0;
            ocw3_rr     <= 1'b0;
            ocw3_ris    <= 1'b0;
            ocw3_smm    <= 1'b0;
        end else begin
            ocw2_valid <= 1'b0;
            if (commit_s) begin
                if (icw1_s) begin
                    // ICW1 restarts initialization from any state.
                    ltim      <= data_r[3];
                    sngl      <= data_r[1];
                    ic4       <= data_r[0];
                    icw3      <= 8'h00;
                    aeoi      <= 1'b0;
                    upm       <= 1'b0;
                    ocw3_rr   <= 1'b0;
                    ocw3_ris  <= 1'b0;
                    ocw3_smm  <= 1'b0;
                    imr       <= 8'h00;
                    init_done <= 1'b0;
                    state_r   <= WAIT_ICW2;
                end else begin
                    case (state_r)
                        IDLE: begin
                            state_r <= IDLE;
                        end
                        WAIT_ICW2: begin
                            if (a0_r) begin
                                vector_base <= data_r[7:3];
                                if (!sngl) begin
                                    state_r <= WAIT_ICW3;
                                end else if (ic4) begin
                                    state_r <= WAIT_ICW4;
                                end else begin
                                    state_r   <= READY;
                                    init_done <= 1'b1;
                                end
                            end
                        end
                        WAIT_ICW3: begin
                            if (a0_r) begin
                                icw3 <= data_r;
                                if (ic4) begin
                                    state_r <= WAIT_ICW4;
                                end else begin
                                    state_r   <= READY;
                                    init_done <= 1'b1;
                                end
                            end
                        end
                        WAIT_ICW4: begin
                            if (a0_r) begin
                                aeoi      <= data_r[1];
                                upm       <= data_r[0];
                                state_r   <= READY;
                                init_done <= 1'b1;
                            end
                        end
                        READY: begin
                            if (a0_r) begin
                                imr <= data_r;
                            end else if (!data_r[3]) begin
                                ocw2       <= data_r;
                                ocw2_valid <= 1'b1;
                            end else begin
`ifdef OCW3_DECODE_EN
                                // RR only latches on a set bit; RIS and SMM follow the byte.
                                ocw3_smm <= data_r[5];
                                ocw3_ris <= data_r[0];
                                if (data_r[1]) begin
                                    ocw3_rr <= 1'b1;
                                end
`else
                                ocw3_rr  <= 1'b0;
                                ocw3_ris <= 1'b0;
                                ocw3_smm <= 1'b0;
`endif
                            end
                        end
                        default: begin
                            state_r <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_icw_sequencer.sv
// Self-checking bench for icw_sequencer: directed scenarios followed by random
// writes, all compared against a pending-word-queue reference model.
module tb_icw_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       init_done;
    logic [4:0] vector_base;
    logic       ltim, sngl, ic4;
    logic [7:0] icw3;
    logic       aeoi, upm;
    logic [7:0] imr;
    logic [7:0] ocw2;
    logic       ocw2_valid;
    logic       ocw3_rr, ocw3_ris, ocw3_smm;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    icw_sequencer_if bus ();

    icw_sequencer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus.slave),
        .init_done   (init_done),
        .vector_base (vector_base),
        .ltim        (ltim),
        .sngl        (sngl),
        .ic4         (ic4),
        .icw3        (icw3),
        .aeoi        (aeoi),
        .upm         (upm),
        .imr         (imr),
        .ocw2        (ocw2),
        .ocw2_valid  (ocw2_valid),
        .ocw3_rr     (ocw3_rr),
        .ocw3_ris    (ocw3_ris),
        .ocw3_smm    (ocw3_smm)
    );

    // Reference model: configuration seen so far plus the queue of init words still owed.
    bit         m_seen;
    bit         m_init;
    logic [4:0] m_vb;
    bit         m_ltim, m_sngl, m_ic4, m_aeoi, m_upm, m_rr, m_ris, m_smm;
    logic [7:0] m_icw3, m_imr, m_ocw2;
    int         pend[$];

    function automatic void model_reset();
        m_seen = 1'b0; m_init = 1'b0; m_vb = 5'h00;
        m_ltim = 1'b0; m_sngl = 1'b0; m_ic4 = 1'b0; m_aeoi = 1'b0; m_upm = 1'b0;
        m_rr = 1'b0; m_ris = 1'b0; m_smm = 1'b0;
        m_icw3 = 8'h00; m_imr = 8'hFF; m_ocw2 = 8'h00;
        pend.delete();
    endfunction

    // Applies one completed write; returns 1 when an OCW2 strobe is expected.
    function automatic bit model_write(bit cs_n, bit a0, logic [7:0] d);
        int w;
        bit pulse;
        pulse = 1'b0;
        if (cs_n) return 1'b0;
        if (!a0 && d[4]) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_icw3 = 8'h00; m_aeoi = 1'b0; m_upm = 1'b0;
            m_rr = 1'b0; m_ris = 1'b0; m_smm = 1'b0;
            m_imr = 8'h00; m_init = 1'b0; m_seen = 1'b1;
            pend.delete();
            pend.push_back(2);
            if (!d[1]) pend.push_back(3);
            if (d[0]) pend.push_back(4);
        end else if (!m_seen) begin
            pulse = 1'b0;
        end else if (pend.size() != 0) begin
            if (a0) begin
                w = pend.pop_front();
                case (w)
                    2: m_vb = d[7:3];
                    3: m_icw3 = d;
                    default: begin m_aeoi = d[1]; m_upm = d[0]; end
                endcase
                if (pend.size() == 0) m_init = 1'b1;
            end
        end else if (a0) begin
            m_imr = d;
        end else if (!d[3]) begin
            m_ocw2 = d;
            pulse  = 1'b1;
        end else begin
`ifdef OCW3_DECODE_EN
            m_smm = d[5];
            m_ris = d[0];
            if (d[1]) m_rr = 1'b1;
`endif
        end
        return pulse;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit ev);
        check("init_done", {7'h00, init_done}, {7'h00, m_init});
        check("vector_base", {3'h0, vector_base}, {3'h0, m_vb});
        check("ltim", {7'h00, ltim}, {7'h00, m_ltim});
        check("sngl", {7'h00, sngl}, {7'h00, m_sngl});
        check("ic4", {7'h00, ic4}, {7'h00, m_ic4});
        check("icw3", icw3, m_icw3);
        check("aeoi", {7'h00, aeoi}, {7'h00, m_aeoi});
        check("upm", {7'h00, upm}, {7'h00, m_upm});
        check("imr", imr, m_imr);
        check("ocw2", ocw2, m_ocw2);
        check("ocw2_valid", {7'h00, ocw2_valid}, {7'h00, ev});
        check("ocw3_rr", {7'h00, ocw3_rr}, {7'h00, m_rr});
        check("ocw3_ris", {7'h00, ocw3_ris}, {7'h00, m_ris});
        check("ocw3_smm", {7'h00, ocw3_smm}, {7'h00, m_smm});
    endtask

    // One CPU write; earlier low samples may carry junk, only the last one counts.
    task automatic do_write(input bit cs_n, input bit a0, input logic [7:0] d,
                            input int low_cycles, input bit glitch);
        bit ev;
        @(negedge CLK);
        bus.WR_N = 1'b0;
        if (glitch && low_cycles > 1) begin
            bus.CS_N = ~cs_n;
            bus.A0   = ~a0;
            bus.InternalData_in = 8'($urandom);
        end else begin
            bus.CS_N = cs_n;
            bus.A0   = a0;
            bus.InternalData_in = d;
        end
        for (int i = 1; i < low_cycles; i++) begin
            @(negedge CLK);
            bus.CS_N = cs_n;
            bus.A0   = a0;
            bus.InternalData_in = d;
        end
        @(negedge CLK);
        bus.WR_N = 1'b1;
        bus.CS_N = 1'b1;
        check_all(1'b0);
        ev = model_write(cs_n, a0, d);
        @(posedge CLK);
        #1;
        check_all(ev);
    endtask

    task automatic wr(input bit a0, input logic [7:0] d);
        do_write(1'b0, a0, d, 1, 1'b0);
    endtask

    // Pending ICW1 interrupted by reset must never commit after release.
    task automatic reset_during_write();
        @(negedge CLK);
        bus.WR_N = 1'b0; bus.CS_N = 1'b0; bus.A0 = 1'b0; bus.InternalData_in = 8'h13;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all(1'b0);
        check("rst_imr", imr, 8'hFF);
        @(negedge CLK);
        RST_N = 1'b1;
        bus.WR_N = 1'b1; bus.CS_N = 1'b1;
        @(posedge CLK);
        #1;
        check_all(1'b0);
        check("post_rst_imr", imr, 8'hFF);
    endtask

    initial begin
        bit cs_n, a0, gl;
        logic [7:0] d;
        int r;

        RST_N = 1'b0;
        bus.WR_N = 1'b1; bus.CS_N = 1'b1; bus.A0 = 1'b0; bus.InternalData_in = 8'h00;
        model_reset();
        repeat (3) @(negedge CLK);
        check_all(1'b0);
        check("reset_imr", imr, 8'hFF);
        check("reset_init", {7'h00, init_done}, 8'h00);
        RST_N = 1'b1;

        // Single, with ICW4
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h40);
        check("icw2_no_init", {7'h00, init_done}, 8'h00);
        wr(1'b1, 8'h03);
        check("s_sngl", {7'h00, sngl}, 8'h01);
        check("s_ic4", {7'h00, ic4}, 8'h01);
        check("s_vb", {3'h0, vector_base}, 8'h08);
        check("s_aeoi", {7'h00, aeoi}, 8'h01);
        check("s_upm", {7'h00, upm}, 8'h01);
        check("s_init", {7'h00, init_done}, 8'h01);

        // Cascade through ICW3
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h04);
        check("c_icw3", icw3, 8'h04);
        check("c_init_before_icw4", {7'h00, init_done}, 8'h00);
        wr(1'b1, 8'h01);
        check("c_init", {7'h00, init_done}, 8'h01);

        // READY: OCW1 and OCW2
        wr(1'b1, 8'hA5);
        check("imr_a5", imr, 8'hA5);
        wr(1'b0, 8'h20);
        check("ocw2_val", ocw2, 8'h20);
        check("ocw2_pulse", {7'h00, ocw2_valid}, 8'h01);
        @(posedge CLK);
        #1;
        check("ocw2_pulse_end", {7'h00, ocw2_valid}, 8'h00);

        // Re-init from READY, then a non-ICW A0=0 write is ignored
        wr(1'b0, 8'h12);
        check("reinit_init", {7'h00, init_done}, 8'h00);
        check("reinit_imr", imr, 8'h00);
        wr(1'b0, 8'h20);
        check("ignored_valid", {7'h00, ocw2_valid}, 8'h00);
        wr(1'b1, 8'h48);

        // Deselected write and reset in mid-write
        do_write(1'b1, 1'b1, 8'h5A, 2, 1'b0);
        check("cs_imr", imr, 8'h00);
        do_write(1'b1, 1'b1, 8'h77, 3, 1'b1);
        reset_during_write();

        // OCW3
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h48);
        wr(1'b0, 8'h0B);
`ifdef OCW3_DECODE_EN
        check("ocw3_rr_set", {7'h00, ocw3_rr}, 8'h01);
        check("ocw3_ris_set", {7'h00, ocw3_ris}, 8'h01);
`else
        check("ocw3_rr_off", {7'h00, ocw3_rr}, 8'h00);
        check("ocw3_ris_off", {7'h00, ocw3_ris}, 8'h00);
`endif
        wr(1'b0, 8'h68);
`ifdef OCW3_DECODE_EN
        check("ocw3_smm_set", {7'h00, ocw3_smm}, 8'h01);
        check("ocw3_rr_hold", {7'h00, ocw3_rr}, 8'h01);
`else
        check("ocw3_smm_off", {7'h00, ocw3_smm}, 8'h00);
        check("ocw3_rr_off2", {7'h00, ocw3_rr}, 8'h00);
`endif

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r    = $urandom_range(0, 99);
            cs_n = ($urandom_range(0, 99) < 8);
            gl   = ($urandom_range(0, 3) == 0);
            d    = 8'($urandom);
            if (r < 2) begin
                reset_during_write();
            end else begin
                if (r < 12) begin
                    a0 = 1'b0;
                    d[4] = 1'b1;
                end else begin
                    a0 = 1'($urandom);
                    if (!a0) d[4] = 1'b0;
                end
                do_write(cs_n, a0, d, $urandom_range(1, 3), gl);
            end
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icw_sequencer.md
ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: CLK  in  1  rising-edge clock, listed first.
REQ-002 RST_N  in  1  asynchronous active-low reset, listed second.
REQ-003 CS_N  in  1  chip select, active low.
REQ-004 WR_N  in  1  CPU write strobe, active low.
REQ-005 A0  in  1  register address bit.
REQ-006 InternalData_in  in  8  internal data bus driven by the data buffer during CPU writes.
REQ-007 init_done  out  1  high once the initialization sequence has completed.
REQ-008 vector_base  out  5  ICW2 bits [7:3].
REQ-009 ltim / sngl / ic4  out  1 each  ICW1 bits 3 / 1 / 0.
REQ-010 icw3  out  8  cascade configuration byte.
REQ-011 aeoi / upm  out  1 each  ICW4 bits 1 / 0.
REQ-012 imr  out  8  interrupt mask register (OCW1).
REQ-013 ocw2  out  8 and ocw2_valid  out  1  last OCW2 byte plus a one-cycle strobe.
REQ-014 ocw3_rr / ocw3_ris / ocw3_smm  out  1 each  OCW3 bits 1 / 0 / 5.

Function
REQ-015 While WR_N samples 0, the block SHALL register CS_N, A0 and InternalData_in on every CLK edge.
REQ-016 A commit SHALL occur on the first CLK edge at which WR_N samples 1 after a 0 sample, and only if the registered CS_N is 0.
REQ-017 All register and state updates SHALL take effect on the commit edge, using the registered A0 and data, giving zero added cycles of latency.
REQ-018 The state machine SHALL have exactly the states IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4 and READY.
REQ-019 ICW1 decode (A0=0, D4=1) SHALL, from any state:
- store ltim, sngl and ic4;
- clear icw3, aeoi, upm and the OCW3 outputs;
- set imr to 8'h00;
- clear init_done;
- go to WAIT_ICW2.
REQ-020 In WAIT_ICW2, an A0=1 write SHALL store vector_base and go to:
- WAIT_ICW3 if sngl=0;
- otherwise WAIT_ICW4 if ic4=1;
- otherwise READY.
REQ-021 In WAIT_ICW3, an A0=1 write SHALL store icw3 and go to WAIT_ICW4 if ic4=1, otherwise to READY.
REQ-022 In WAIT_ICW4, an A0=1 write SHALL store aeoi and upm and go to READY.
REQ-023 Entering READY SHALL set init_done=1 on the same edge.
REQ-024 In the WAIT_* states, an A0=0 write with D4=0 SHALL be ignored.
REQ-025 In IDLE, every write except ICW1 SHALL be ignored.
REQ-026 In READY, an A0=1 write SHALL load imr with the data byte.
REQ-027 In READY, an A0=0 write with D4=0 and D3=0 SHALL load ocw2 and pulse ocw2_valid high for exactly one cycle.
REQ-028 In READY, an A0=0 write with D4=0 and D3=1 SHALL be treated as OCW3 (see Configuration).
REQ-029 ocw2_valid SHALL be 0 in every cycle other than an OCW2 commit.
REQ-030 A write with CS_N deasserted at any point during the low phase of WR_N, as captured by the last low sample, SHALL cause no state change.

Reset
REQ-031 RST_N low SHALL immediately force:
- state IDLE;
- init_done 0;
- imr 8'hFF;
- every other output 0, including ocw2_valid;
- the capture registers to WR_N=1 and CS_N=1.
REQ-032 A reset asserted while WR_N is low SHALL discard the pending write, so that no commit occurs after the reset is released.

Configuration
REQ-033 Macro OCW3_DECODE_EN SHALL select OCW3 handling.
- Defined: an OCW3 write in READY updates ocw3_smm from D5 and ocw3_ris from D0 unconditionally, and updates ocw3_rr from D1 only when D1=1 (D1=0 leaves ocw3_rr unchanged).
- Undefined: OCW3 writes are ignored and all three ocw3_* outputs are held at 0.

Verification
REQ-034 The bench SHALL cover: reset, then writes of ICW1=8'h13 and ICW2=8'h40, then ICW4=8'h03 -> sngl=1, ic4=1, vector_base=5'h08, aeoi=1, upm=1, and init_done rises on the ICW4 commit edge.
REQ-035 The bench SHALL cover: ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01 -> passes through WAIT_ICW3, icw3=8'h04, init_done=1.
REQ-036 The bench SHALL cover: in READY, an A0=1 write of 8'hA5 -> imr=8'hA5; then a write of 8'h20 with A0=0 -> ocw2=8'h20 with ocw2_valid high for 1 cycle.
REQ-037 The bench SHALL cover: in READY, ICW1=8'h12 -> init_done=0 and imr=8'h00; a following A0=0 write of 8'h20 -> ignored, with ocw2_valid staying 0.
REQ-038 The bench SHALL cover: a write with CS_N=1 -> no change; RST_N pulsed low while WR_N=0 -> all outputs at reset values and no commit after release.
REQ-039 The bench SHALL cover, with OCW3_DECODE_EN defined: in READY, OCW3=8'h0B -> ocw3_rr=1 and ocw3_ris=1; then OCW3=8'h68 -> ocw3_smm=1 and ocw3_rr still 1. Without the macro, all ocw3_* outputs stay 0.
